// File: rtl/div.sv
// Radix-2 restoring 32-bit divider for DIV/DIVU; result {remainder, quotient}.
// Latency 33 edges after acceptance (divide-by-zero: 2); result held while start_i stays high.
module div #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam logic [1:0] S_FREE   = 2'b00;
  localparam logic [1:0] S_BYZERO = 2'b01;
  localparam logic [1:0] S_ON     = 2'b10;
  localparam logic [1:0] S_END    = 2'b11;

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  signed_q, signed_d;
  logic                  quo_neg_q, quo_neg_d;
  logic                  rem_neg_q, rem_neg_d;
  logic [DATA_W-1:0]     dividend_q, dividend_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  logic [DATA_W-1:0]     op1_mag, op2_mag;
  logic [DATA_W:0]       shift_rem;
  logic [DATA_W+1:0]     trial;
  logic                  take;
  logic [DATA_W-1:0]     quo_fix, rem_fix;
  logic                  trial_unused;

  // Magnitudes only for signed operands; 0x80000000 maps onto itself, which is
  // exactly its unsigned magnitude.
  always_comb begin
    op1_mag = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    op2_mag = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  end

  // One restoring step: the dividend register shifts its MSB into the partial
  // remainder and collects quotient bits at its LSB. A kept difference is always
  // below the divisor, so it fits DATA_W bits.
  always_comb begin
    shift_rem = {rem_q, dividend_q[DATA_W-1]};
    trial     = {1'b0, shift_rem} - {2'b00, divisor_q};
    take      = ~trial[DATA_W+1];
    quo_fix   = (signed_q && quo_neg_q) ? -dividend_q : dividend_q;
    rem_fix   = (signed_q && rem_neg_q) ? -rem_q : rem_q;
  end

  assign trial_unused = trial[DATA_W];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    signed_d   = signed_q;
    quo_neg_d  = quo_neg_q;
    rem_neg_d  = rem_neg_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      S_FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end else begin
            state_d    = S_ON;
            signed_d   = signed_div_i;
            dividend_d = op1_mag;
            divisor_d  = op2_mag;
            quo_neg_d  = opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1];
            rem_neg_d  = opdata1_i[DATA_W-1];
            rem_d      = '0;
            cnt_d      = '0;
          end
        end
      end

      S_BYZERO: begin
        state_d  = S_END;
        result_d = '0;
        ready_d  = 1'b0;
      end

      S_ON: begin
        if (annul_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt_q != CNT_LAST) begin
          rem_d      = take ? trial[DATA_W-1:0] : shift_rem[DATA_W-1:0];
          dividend_d = {dividend_q[DATA_W-2:0], take};
          cnt_d      = cnt_q + CNT_W'(1);
        end else begin
          state_d  = S_END;
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
        end
      end

      S_END: begin
        if (!start_i || annul_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          // Divide-by-zero arrives here with ready low and publishes its zero
          // result one edge after entry; the normal path is already ready.
          ready_d = 1'b1;
        end
      end

      default: begin
        state_d  = S_FREE;
        ready_d  = 1'b0;
        result_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FREE;
      cnt_q      <= '0;
      signed_q   <= 1'b0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      signed_q   <= signed_d;
      quo_neg_q  <= quo_neg_d;
      rem_neg_q  <= rem_neg_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
